axis_packet_checker: RTL and testbench



---
 rtl/axis_test_pkg.sv | 23 ++
 rtl/axis_packet_checker_if.sv | 12 +
 rtl/axis_ready_shaper.sv | 45 ++++
 rtl/axis_packet_checker.sv | 133 +++++++++++++
 tb/tb_axis_packet_checker.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/axis_test_pkg.sv
// Shared constants for the matrix-multiplier test-packet stream sinks:
// packet format defaults, error codes and checker FSM encoding.
package axis_test_pkg;

  localparam logic [31:0] HEADER_WORD_DEFAULT = 32'h02010360;
  localparam logic [7:0]  PAYLOAD_LEN_DEFAULT = 8'd216;

  localparam logic [2:0] ERR_NONE         = 3'd0;
  localparam logic [2:0] ERR_HEADER       = 3'd1;
  localparam logic [2:0] ERR_DATA         = 3'd2;
  localparam logic [2:0] ERR_EARLY_LAST   = 3'd3;
  localparam logic [2:0] ERR_MISSING_LAST = 3'd4;

  localparam logic [1:0] StWaitStart = 2'd0;
  localparam logic [1:0] StHeader    = 2'd1;
  localparam logic [1:0] StPayload   = 2'd2;
  localparam logic [1:0] StDrain     = 2'd3;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/axis_packet_checker_if.sv
// AXI4-Stream beat signals (32-bit data, TLAST) with source/sink modports.
interface axis_packet_checker_if;

  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_ready_shaper.sv
// Start-up hold-off and rotating-mask back-pressure for stream sinks; TREADY is registered
// and never looks at TVALID.
module axis_ready_shaper #(
  parameter logic [15:0] START_DELAY   = 16'd16,
  parameter logic [7:0]  READY_PATTERN = 8'hFF
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting_i,     // sink is still in its start-up state
  input  logic run_next_i,    // sink leaves (or is past) start-up next cycle
  output logic start_done_o,
  output logic tready_o
);

  logic [15:0] delay_q, delay_d;
  logic [2:0]  ptr_q, ptr_d, ptr_inc;
  logic        tready_q, tready_d;

  always_comb begin
    // Last start-up cycle is the one where delay_q == START_DELAY-1.
    start_done_o = ({1'b0, delay_q} + 17'd1) >= {1'b0, START_DELAY};
    delay_d      = delay_q;
    if (waiting_i && !start_done_o) begin
      delay_d = delay_q + 16'd1;
    end
    ptr_inc  = ptr_q + 3'd1;
    ptr_d    = waiting_i ? ptr_q : ptr_inc;
    tready_d = run_next_i ? READY_PATTERN[ptr_inc] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      delay_q  <= 16'd0;
      ptr_q    <= 3'd0;
      tready_q <= 1'b0;
    end else begin
      delay_q  <= delay_d;
      ptr_q    <= ptr_d;
      tready_q <= tready_d;
    end
  end

  assign tready_o = tready_q;

endmodule

// File: rtl/axis_packet_checker.sv
// Sink that verifies header + counting-payload test packets and keeps saturating
// good/bad packet counters plus the most recent error code.
module axis_packet_checker
  import axis_test_pkg::*;
#(
  parameter logic [31:0] HEADER_WORD   = HEADER_WORD_DEFAULT,
  parameter logic [7:0]  PAYLOAD_LEN   = PAYLOAD_LEN_DEFAULT,
  parameter logic [15:0] START_DELAY   = 16'd16,
  parameter logic [7:0]  READY_PATTERN = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  axis_packet_checker_if.slave  s_axis,
  output logic [15:0]           pkt_count,
  output logic [15:0]           err_count,
  output logic                  err_flag,
  output logic [2:0]            last_err_code,
  output logic                  busy
);

  logic [1:0]  state_q, state_d;
  logic [7:0]  beat_q, beat_d;
  logic [15:0] pkt_q, pkt_d, errc_q, errc_d;
  logic        flag_q, flag_d, busy_q, busy_d;
  logic [2:0]  code_q, code_d, err_code;
  logic        tready, start_done, accept;

  axis_ready_shaper #(
    .START_DELAY   (START_DELAY),
    .READY_PATTERN (READY_PATTERN)
  ) u_ready_shaper (
    .clk          (clk),
    .reset        (reset),
    .waiting_i    (state_q == StWaitStart),
    .run_next_i   (state_d != StWaitStart),
    .start_done_o (start_done),
    .tready_o     (tready)
  );

  assign s_axis.tready = tready;
  assign accept        = s_axis.tvalid & tready;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    pkt_d    = pkt_q;
    errc_d   = errc_q;
    flag_d   = flag_q;
    code_d   = code_q;
    busy_d   = busy_q;
    err_code = ERR_NONE;

    case (state_q)
      StWaitStart: begin
        if (start_done) state_d = StHeader;
      end
      StHeader: begin
        if (accept) begin
          if (s_axis.tdata != HEADER_WORD) begin
            err_code = ERR_HEADER;
            state_d  = s_axis.tlast ? StHeader : StDrain;
          end else if (s_axis.tlast) begin
            err_code = ERR_EARLY_LAST;
          end else begin
            state_d = StPayload;
            beat_d  = 8'd1;
            busy_d  = 1'b1;
          end
        end
      end
      StPayload: begin
        if (accept) begin
          if (s_axis.tdata != {24'd0, beat_q}) begin
            err_code = ERR_DATA;
          end else if (s_axis.tlast && (beat_q < PAYLOAD_LEN)) begin
            err_code = ERR_EARLY_LAST;
          end else if (!s_axis.tlast && (beat_q == PAYLOAD_LEN)) begin
            err_code = ERR_MISSING_LAST;
          end

          if (err_code != ERR_NONE) begin
            state_d = s_axis.tlast ? StHeader : StDrain;
          end else if (s_axis.tlast) begin
            state_d = StHeader;
            pkt_d   = sat_inc(pkt_q);
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      StDrain: begin
        if (accept && s_axis.tlast) state_d = StHeader;
      end
      default: state_d = StWaitStart;
    endcase

    if (accept && s_axis.tlast) busy_d = 1'b0;

    // Every error path leaves the checking states, so each packet reports at most once.
    if (err_code != ERR_NONE) begin
      errc_d = sat_inc(errc_q);
      flag_d = 1'b1;
      code_d = err_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StWaitStart;
      beat_q  <= 8'd0;
      pkt_q   <= 16'd0;
      errc_q  <= 16'd0;
      flag_q  <= 1'b0;
      code_q  <= ERR_NONE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
      errc_q  <= errc_d;
      flag_q  <= flag_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
    end
  end

  assign pkt_count     = pkt_q;
  assign err_count     = errc_q;
  assign err_flag      = flag_q;
  assign last_err_code = code_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_axis_packet_checker.sv
// Scoreboard bench: expected counter state is queued per packet and compared when the
// packet's TLAST beat is accepted.
module tb_axis_packet_checker;

  localparam logic [31:0] Hdr = 32'h02010360;

  typedef struct {
    logic [15:0] pkt;
    logic [15:0] err;
    logic        flag;
    logic [2:0]  code;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic [31:0] tdata = 32'd0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  exp_t        exp_q[$];
  logic [15:0] m_pkt = 16'd0, m_err = 16'd0;
  logic        m_flag = 1'b0;
  logic [2:0]  m_code = 3'd0;
  logic        acc_last_q = 1'b0;

  axis_packet_checker_if if_a ();
  axis_packet_checker_if if_b ();

  logic [15:0] a_pkt, a_err, b_pkt, b_err;
  logic        a_flag, a_busy, b_flag, b_busy;
  logic [2:0]  a_code, b_code;

  assign if_a.tdata  = tdata;
  assign if_a.tlast  = tlast;
  assign if_a.tvalid = tvalid & ~sel;
  assign if_b.tdata  = tdata;
  assign if_b.tlast  = tlast;
  assign if_b.tvalid = tvalid & sel;

  axis_packet_checker u_dut_a (
    .clk           (clk),
    .reset         (reset),
    .s_axis        (if_a),
    .pkt_count     (a_pkt),
    .err_count     (a_err),
    .err_flag      (a_flag),
    .last_err_code (a_code),
    .busy          (a_busy)
  );

  axis_packet_checker #(
    .READY_PATTERN (8'hAA)
  ) u_dut_b (
    .clk           (clk),
    .reset         (reset),
    .s_axis        (if_b),
    .pkt_count     (b_pkt),
    .err_count     (b_err),
    .err_flag      (b_flag),
    .last_err_code (b_code),
    .busy          (b_busy)
  );

  logic [15:0] pkt_m, err_m;
  logic        flag_m, busy_m, tready_m;
  logic [2:0]  code_m;
  assign pkt_m    = sel ? b_pkt : a_pkt;
  assign err_m    = sel ? b_err : a_err;
  assign flag_m   = sel ? b_flag : a_flag;
  assign code_m   = sel ? b_code : a_code;
  assign busy_m   = sel ? b_busy : a_busy;
  assign tready_m = sel ? if_b.tready : if_a.tready;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model of the counters: bench-side expectation for each packet's outcome.
  task automatic push_exp(input logic [2:0] code);
    if (code == 3'd0) begin
      if (m_pkt != 16'hFFFF) m_pkt = m_pkt + 16'd1;
    end else begin
      if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
      m_flag = 1'b1;
      m_code = code;
    end
    exp_q.push_back('{m_pkt, m_err, m_flag, m_code});
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_beat(input logic [31:0] d, input logic l);
    int n = 0;
    tdata  = d;
    tlast  = l;
    tvalid = 1'b1;
    while (!tready_m && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      check_eq("accept_wait", 32'(n), 32'd0);
      tvalid = 1'b0;
      return;
    end
    @(negedge clk);
  endtask

  task automatic send_pkt(input logic [31:0] hdr, input int n_beats, input int bad_beat,
                          input logic [31:0] bad_val, input logic [2:0] code);
    push_exp(code);
    send_beat(hdr, n_beats == 0);
    if (n_beats > 0) check_eq("busy_after_hdr", 32'(busy_m), 32'(hdr == Hdr));
    for (int i = 1; i <= n_beats; i++) begin
      send_beat((i == bad_beat) ? bad_val : 32'(i), i == n_beats);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    int n = 0;
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset  = 1'b0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    m_pkt  = 16'd0;
    m_err  = 16'd0;
    m_flag = 1'b0;
    m_code = 3'd0;
    exp_q.delete();
    check_eq("rst_pkt", 32'(pkt_m), 32'd0);
    check_eq("rst_err", 32'(err_m), 32'd0);
    check_eq("rst_flag", 32'(flag_m), 32'd0);
    check_eq("rst_code", 32'(code_m), 32'd0);
    check_eq("rst_busy", 32'(busy_m), 32'd0);
    check_eq("rst_tready", 32'(tready_m), 32'd0);
    while (!tready_m && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_eq("start_delay", 32'(n), 32'd16);
  endtask

  always @(posedge clk) acc_last_q <= !reset && tvalid && tready_m && tlast;

  always @(negedge clk) begin
    if (acc_last_q) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_nonempty", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("sb_pkt_count", 32'(pkt_m), 32'(e.pkt));
        check_eq("sb_err_count", 32'(err_m), 32'(e.err));
        check_eq("sb_err_flag", 32'(flag_m), 32'(e.flag));
        check_eq("sb_err_code", 32'(code_m), 32'(e.code));
        check_eq("sb_busy", 32'(busy_m), 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int highs;
    @(negedge clk);
    do_reset(3);

    // 1: clean packet
    send_pkt(Hdr, 216, 0, 32'd0, 3'd0);
    // 2: bad payload beat 5, then clean
    send_pkt(Hdr, 216, 5, 32'h7, 3'd2);
    send_pkt(Hdr, 216, 0, 32'd0, 3'd0);
    // 3: early TLAST on beat 100, then bad header drained to TLAST
    send_pkt(Hdr, 100, 0, 32'd0, 3'd3);
    send_pkt(32'h12345678, 216, 0, 32'd0, 3'd1);
    // 4: missing TLAST on 216, packet runs to 220; one error only
    send_pkt(Hdr, 220, 0, 32'd0, 3'd4);
    send_pkt(Hdr, 216, 0, 32'd0, 3'd0);
    repeat (4) @(negedge clk);

    // 5: alternating back-pressure on the second instance
    sel    = 1'b1;
    m_pkt  = 16'd0;
    m_err  = 16'd0;
    m_flag = 1'b0;
    m_code = 3'd0;
    t0 = cyc;
    send_pkt(Hdr, 216, 0, 32'd0, 3'd0);
    check_eq("alt_duration_ok", 32'((cyc - t0) >= 430 && (cyc - t0) <= 440), 32'd1);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      if (tready_m) highs++;
      @(negedge clk);
    end
    check_eq("alt_ready_duty", 32'(highs), 32'd20);
    repeat (4) @(negedge clk);
    sel = 1'b0;
    @(negedge clk);

    // 6: reset in the middle of a packet
    send_beat(Hdr, 1'b0);
    for (int i = 1; i <= 49; i++) send_beat(32'(i), 1'b0);
    tdata  = 32'd50;
    tvalid = 1'b1;
    do_reset(1);
    send_pkt(Hdr, 216, 0, 32'd0, 3'd0);
    repeat (4) @(negedge clk);

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
